// File: rtl/link_8b10b_pkg.sv
// link_8b10b_pkg: K-symbol codes, scheduler states and frame types for the audio link transmitter.
package link_8b10b_pkg;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K29_7 = 8'hFD;
  typedef enum logic [2:0] {S_IDLE, S_SOF, S_PAY0, S_PAY1, S_EOF} stateT;
  typedef enum logic {FT_AUDIO, FT_CTRL} frameT;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; bit 0 = audio, bit 1 = ctrl, last grant resets to ctrl.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       update,
  output logic [1:0] grant
);
  logic lastCtrl;
  always_comb grant = !enable ? 2'b00 : (&req) ? (lastCtrl ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk)
    if (reset) lastCtrl <= 1'b1;
    else if (update && |grant) lastCtrl <= grant[1];
endmodule

// File: rtl/link_tx_scheduler.sv
// link_tx_scheduler: frames audio/ctrl grants in K-codes, fills idle slots with K28.5 and bounds comma spacing.
module link_tx_scheduler
  import link_8b10b_pkg::*;
#(
  parameter int COMMA_PERIOD = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        link_enable,
  input  logic        audio_valid,
  input  logic [15:0] audio_data,
  output logic        audio_ready,
  input  logic        ctrl_valid,
  input  logic [7:0]  ctrl_data,
  output logic        ctrl_ready,
  output logic        tx_k,
  output logic [7:0]  tx_data,
  output logic [15:0] frame_count
);
  localparam int CW = $clog2(COMMA_PERIOD + 1);
  localparam logic [CW-1:0] PERIOD = CW'(COMMA_PERIOD);
  stateT state, nextState;
  frameT frameType, nextType;
  logic [15:0] payload, nextPayload;
  logic [CW-1:0] commaCnt;
  logic commaDue, grantOk, nextK;
  logic [1:0] grant;
  logic [7:0] nextData;
  assign commaDue = commaCnt >= PERIOD;
  assign grantOk = !reset && link_enable && (state == S_IDLE || (state == S_EOF && !commaDue));
  rr_arbiter2 arb (
    .clk(clk),
    .reset(reset),
    .req({ctrl_valid, audio_valid}),
    .enable(grantOk),
    .update(grantOk),
    .grant(grant)
  );
  assign audio_ready = grant[0];
  assign ctrl_ready = grant[1];
  always_comb begin
    nextType = grant[1] ? FT_CTRL : grant[0] ? FT_AUDIO : frameType;
    nextPayload = grant[1] ? {ctrl_data, 8'h00} : grant[0] ? audio_data : payload;
    nextState = S_IDLE;
    case (state)
      S_IDLE, S_EOF: nextState = |grant ? S_SOF : S_IDLE;
      S_SOF:         nextState = S_PAY0;
      S_PAY0:        nextState = frameType == FT_AUDIO ? S_PAY1 : S_EOF;
      S_PAY1:        nextState = S_EOF;
      default:       nextState = S_IDLE;
    endcase
    nextK = 1'b1;
    nextData = K28_5;
    case (nextState)
      S_SOF:   nextData = nextType == FT_AUDIO ? K27_7 : K28_2;
      S_PAY0:  {nextK, nextData} = {1'b0, nextPayload[15:8]};
      S_PAY1:  {nextK, nextData} = {1'b0, nextPayload[7:0]};
      S_EOF:   nextData = K29_7;
      default: nextData = K28_5;
    endcase
  end
  // tx is the registered symbol of the state being entered, so it always lines up with state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      frameType <= FT_AUDIO;
      payload <= '0;
      commaCnt <= '0;
      frame_count <= '0;
      tx_k <= 1'b1;
      tx_data <= K28_5;
    end else begin
      state <= nextState;
      frameType <= nextType;
      payload <= nextPayload;
      commaCnt <= nextState == S_IDLE ? '0 : commaDue ? commaCnt : commaCnt + 1'b1;
      frame_count <= frame_count + 16'(state == S_EOF);
      tx_k <= nextK;
      tx_data <= nextData;
    end
  end
endmodule

// File: tb/tb_link_tx_scheduler.sv
// tb_link_tx_scheduler: directed and random stimulus checked against a symbol-queue model of the link.
module tb_link_tx_scheduler;
  localparam int P = 8;
  localparam logic [8:0] BC9 = 9'h1BC;
  localparam logic [8:0] FD9 = 9'h1FD;
  logic clk = 1'b0;
  logic reset, link_enable, audio_valid, ctrl_valid, audio_ready, ctrl_ready, tx_k;
  logic [15:0] audio_data, frame_count;
  logic [7:0] ctrl_data, tx_data;
  always #5 clk = ~clk;
  link_tx_scheduler #(.COMMA_PERIOD(P)) dut (
    .clk(clk),
    .reset(reset),
    .link_enable(link_enable),
    .audio_valid(audio_valid),
    .audio_data(audio_data),
    .audio_ready(audio_ready),
    .ctrl_valid(ctrl_valid),
    .ctrl_data(ctrl_data),
    .ctrl_ready(ctrl_ready),
    .tx_k(tx_k),
    .tx_data(tx_data),
    .frame_count(frame_count)
  );
  int checks = 0, failures = 0;
  logic [8:0] expQ[$];
  logic [8:0] cur;
  int run, frames, runD, maxRunD, bcSeen;
  bit mLastCtrl, gotA, gotC;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock: check readies mid-cycle, advance the model, check the registered symbol after the edge
  task automatic step();
    bit ok, expA, expC;
    #1;
    ok = !reset && link_enable && expQ.size() == 0 && !(cur == FD9 && run >= P);
    expA = ok && audio_valid && (!ctrl_valid || mLastCtrl);
    expC = ok && ctrl_valid && (!audio_valid || !mLastCtrl);
    check("audio_ready", audio_ready, expA);
    check("ctrl_ready", ctrl_ready, expC);
    gotA = audio_ready;
    gotC = ctrl_ready;
    if (reset) begin
      expQ.delete();
      cur = BC9;
      run = 0;
      frames = 0;
      mLastCtrl = 1'b1;
    end else begin
      if (cur == FD9) frames++;
      if (expA) begin
        expQ.push_back(9'h1FB);
        expQ.push_back({1'b0, audio_data[15:8]});
        expQ.push_back({1'b0, audio_data[7:0]});
        expQ.push_back(FD9);
        mLastCtrl = 1'b0;
      end
      if (expC) begin
        expQ.push_back(9'h15C);
        expQ.push_back({1'b0, ctrl_data});
        expQ.push_back(FD9);
        mLastCtrl = 1'b1;
      end
      if (expQ.size() == 0) expQ.push_back(BC9);
      cur = expQ.pop_front();
      run = cur == BC9 ? 0 : run + 1;
    end
    @(posedge clk);
    #1;
    check("tx_k", tx_k, cur[8]);
    check("tx_data", tx_data, cur[7:0]);
    check("frame_count", frame_count, frames[15:0]);
    if (tx_k && tx_data == 8'hBC) begin
      runD = 0;
      bcSeen++;
    end else begin
      runD++;
      if (runD > maxRunD) maxRunD = runD;
    end
    @(negedge clk);
  endtask
  task automatic waitAudioGrant();
    int n = 0;
    step();
    while (!gotA && n < 20) begin
      step();
      n++;
    end
    check("audio_grant_timeout", gotA, 1'b1);
  endtask
  initial begin
    int grants, altErr, rdyLow;
    bit prevA;
    reset = 1'b1;
    link_enable = 1'b0;
    audio_valid = 1'b0;
    ctrl_valid = 1'b0;
    audio_data = '0;
    ctrl_data = '0;
    cur = BC9;
    run = 0;
    frames = 0;
    mLastCtrl = 1'b1;
    runD = 0;
    maxRunD = 0;
    bcSeen = 0;
    @(negedge clk);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    check("reset_frames", frame_count, 16'd0);
    link_enable = 1'b1;
    audio_valid = 1'b1;
    audio_data = 16'hBEEF;
    step();
    check("beef_grant", gotA, 1'b1);
    check("beef_sof", {tx_k, tx_data}, 9'h1FB);
    audio_valid = 1'b0;
    step();
    check("beef_hi", {tx_k, tx_data}, 9'h0BE);
    step();
    check("beef_lo", {tx_k, tx_data}, 9'h0EF);
    step();
    check("beef_eof", {tx_k, tx_data}, 9'h1FD);
    step();
    check("beef_idle", {tx_k, tx_data}, 9'h1BC);
    check("beef_frames", frame_count, 16'd1);
    ctrl_data = 8'h5A;
    audio_data = 16'($urandom);
    audio_valid = 1'b1;
    ctrl_valid = 1'b1;
    grants = 0;
    altErr = 0;
    prevA = 1'b0;
    repeat (24) begin
      step();
      if (gotA || gotC) begin
        if (grants > 0 && gotA == prevA) altErr++;
        prevA = gotA;
        grants++;
        if (gotA) audio_data = 16'($urandom);
      end
    end
    check("alt_violations", altErr, 0);
    check("alt_grants", grants >= 3, 1'b1);
    audio_valid = 1'b0;
    ctrl_valid = 1'b0;
    repeat (6) step();
    maxRunD = 0;
    bcSeen = 0;
    audio_valid = 1'b1;
    repeat (48) begin
      step();
      if (gotA) audio_data = 16'($urandom);
    end
    check("max_run", maxRunD <= P + 3, 1'b1);
    check("commas_seen", bcSeen > 0, 1'b1);
    audio_valid = 1'b0;
    repeat (6) step();
    audio_valid = 1'b1;
    audio_data = 16'($urandom);
    waitAudioGrant();
    audio_data = 16'($urandom);
    step();
    link_enable = 1'b0;
    rdyLow = 0;
    repeat (8) begin
      step();
      rdyLow += int'(gotA) + int'(gotC);
    end
    check("ready_while_disabled", rdyLow, 0);
    check("disabled_idle", {tx_k, tx_data}, 9'h1BC);
    link_enable = 1'b1;
    step();
    check("resume_grant", gotA, 1'b1);
    audio_valid = 1'b0;
    repeat (6) step();
    audio_valid = 1'b1;
    audio_data = 16'($urandom);
    waitAudioGrant();
    audio_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_tx", {tx_k, tx_data}, 9'h1BC);
    check("abort_frames", frame_count, 16'd0);
    audio_valid = 1'b1;
    audio_data = 16'h1234;
    waitAudioGrant();
    check("clean_sof", {tx_k, tx_data}, 9'h1FB);
    audio_valid = 1'b0;
    step();
    check("clean_hi", {tx_k, tx_data}, 9'h012);
    step();
    check("clean_lo", {tx_k, tx_data}, 9'h034);
    step();
    check("clean_eof", {tx_k, tx_data}, 9'h1FD);
    step();
    check("clean_frames", frame_count, 16'd1);
    repeat (300) begin
      link_enable = $urandom_range(0, 9) != 0;
      reset = $urandom_range(0, 99) == 0;
      if (!audio_valid) begin
        audio_valid = $urandom_range(0, 1) == 1;
        audio_data = 16'($urandom);
      end else if ($urandom_range(0, 15) == 0) audio_valid = 1'b0;
      if (!ctrl_valid) begin
        ctrl_valid = $urandom_range(0, 1) == 1;
        ctrl_data = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) ctrl_valid = 1'b0;
      step();
      if (gotA) audio_valid = 1'b0;
      if (gotC) ctrl_valid = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/link_tx_scheduler.md
# link_tx_scheduler

Byte-slot scheduler feeding the 8b10b encoder's K/data input, one symbol per clock. It arbitrates between an audio-sample requester and a control-message requester and wraps each grant in a K-code frame. It fills unused slots with K28.5 commas and guarantees a bounded comma spacing so the decoder side stays aligned. It sits directly upstream of `encoder_8b10b` in the audio link.

## Interface
- `COMMA_PERIOD`, default 32: max data/K slots between K28.5 commas before one is forced at the next frame boundary (≥4).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `link_enable`  in  1  high = frames may be granted; low = finish current frame, then idle.
- `audio_valid`  in  1  audio sample pending.
- `audio_data`  in  16  sample, sent MSB byte first.
- `audio_ready`  out  1  one-cycle grant; sample latched this cycle.
- `ctrl_valid`  in  1  control byte pending.
- `ctrl_data`  in  8  control payload.
- `ctrl_ready`  out  1  one-cycle grant; byte latched this cycle.
- `tx_k`  out  1  to encoder K input (registered).
- `tx_data`  out  8  to encoder data input (registered).
- `frame_count`  out  16  frames completed since reset, wraps at 0xFFFF→0.

## Operation
- Symbols: IDLE/comma K28.5 = 0xBC; audio SOF K27.7 = 0xFB; ctrl SOF K28.2 = 0x5C; EOF K29.7 = 0xFD. Payload bytes sent with `tx_k`=0.
- Audio frame: FB, data[15:8], data[7:0], FD (4 slots). Ctrl frame: 5C, byte, FD (3 slots).
- FSM states: S_IDLE (emit BC), S_SOF, S_PAY0, S_PAY1 (audio only), S_EOF.
- Decision point: cycle in S_IDLE or S_EOF. Grant when `link_enable`=1, a request is valid, and (in S_EOF) `comma_due`=0. Granting → next state S_SOF. Otherwise → S_IDLE.
- Grant = `*_ready` high for that cycle. Ready is combinational from state, `link_enable`, valids, `comma_due`, and `last_grant`. Payload and frame type are latched on the same edge. At most one ready per cycle; ready is never high outside a decision point.
- Arbitration: 2-way round-robin. Both valid → grant the one not in `last_grant`. Single valid → grant it. `last_grant` resets to ctrl, so audio wins the first tie.
- Requesters hold valid/data until ready. Valid dropping before ready is allowed; no grant results.
- Comma counter: `comma_cnt`, width clog2(COMMA_PERIOD+1). Cleared when BC is emitted; otherwise +1 per slot, saturating at COMMA_PERIOD. `comma_due` = (`comma_cnt` ≥ COMMA_PERIOD).
- `comma_due` at S_EOF forces one S_IDLE slot (one BC) before any further grant. Max non-comma run = COMMA_PERIOD+3 slots.
- `link_enable` deasserted mid-frame: frame completes unchanged; no grant at its S_EOF.
- `frame_count` increments on the edge leaving S_EOF.

## Timing
- Reset (next edge): `tx_k`=1, `tx_data`=0xBC, state S_IDLE, `comma_cnt`=0, `frame_count`=0, `last_grant`=ctrl. Readies are 0 while `reset`=1.
- Reset mid-frame aborts the frame: next symbol is BC, latched payload is discarded, and the frame is not counted.
- Grant in cycle n (in S_IDLE): SOF on `tx_*` after edge n+1, payload after n+2 (and n+3), EOF after n+3 (ctrl) or n+4 (audio).
- Back-to-back: a grant in the S_EOF cycle makes the next frame's SOF follow EOF with zero idle slots.
- Sustained throughput: audio-only = one sample per 4 clocks, except forced commas.

## Structure
- `link_8b10b_pkg`: K-symbol localparams (K28_5, K27_7, K28_2, K29_7), state enum, frame-type enum.
- Sub-module `rr_arbiter2` (req[1:0], enable, update → one-hot grant, last-grant register).
- FSM, payload latch, comma counter, and frame counter live in `link_tx_scheduler`.

## Test plan
- Reset held 3 cycles, no requests, with `tx_k`=1 and `tx_data`=0xBC every cycle → `frame_count`=0 and readies never high.
- Single `audio_valid` with 0xBEEF → `audio_ready` 1 cycle, then K:FB, D:BE, D:EF, K:FD, then BC; `frame_count`=1.
- Audio and ctrl (0x5A) valid continuously → grants alternate audio, ctrl, audio. Stream is FB.. FD 5C 5A FD FB.. with no idle between frames.
- Audio held valid with COMMA_PERIOD=8 → one BC inserted after every second frame. No run of non-BC symbols exceeds 11.
- `link_enable` dropped during PAY0 → frame finishes with FD, then BC continues. No ready while low; grants resume within one cycle of re-enable.
- Reset asserted during an audio PAY1 → BC on the next edge, no FD, `frame_count` 0. A subsequent grant produces a clean FB frame.
